// File: rtl/des_sbox_stage.sv
// Two-stage elastic pipeline for the front half of the DES round function:
// E-expansion and subkey XOR in stage 1, the eight S-boxes in stage 2.
module des_sbox_stage #(
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:31]      r_in,
  input  logic [0:47]      k_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:31]      s_out,
  output logic [TAG_W-1:0] tag_out
);

  // Each S-box is 64 nibbles, entry n = row*16+col at bits [4n:4n+3]; the
  // leftmost hex digit is row 0 / col 0.
  localparam logic [0:255] SBOX [8] = '{
    {64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538,
     64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
    {64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5,
     64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
    {64'hA09E63F51DC7B428, 64'hD709346A285ECBF1,
     64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
    {64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9,
     64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
    {64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986,
     64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
    {64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38,
     64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
    {64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86,
     64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
    {64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92,
     64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}
  };

  logic             v1, v2;
  logic             ready1, ready2;
  logic             ld1, ld2;
  logic [0:47]      x_next, x_reg;
  logic [0:31]      s_next, s_reg;
  logic [TAG_W-1:0] tag1, tag2;

  assign ready2   = !v2 | out_ready;
  assign ready1   = !v1 | ready2;
  assign ld1      = in_valid & ready1;
  assign ld2      = v1 & ready2;
  assign in_ready = ready1;

  for (genvar i = 0; i < 8; i++) begin : g_box
    logic [0:5] grp;
    logic [5:0] idx;

    // E group i wraps around R: bits 4i-1 .. 4i+4 modulo 32.
    assign x_next[6*i +: 6] = {r_in[(4*i+31)%32], r_in[4*i +: 4],
                               r_in[(4*i+4)%32]} ^ k_in[6*i +: 6];

    // Outer bits pick the row, inner four pick the column.
    assign grp = x_reg[6*i +: 6];
    assign idx = {grp[0], grp[5], grp[1:4]};
    assign s_next[4*i +: 4] = SBOX[i][{idx, 2'b00} +: 4];
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values; the data registers are reset as well so the
  // outputs read zero during reset instead of stale results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      x_reg <= '0;
      tag1  <= '0;
      s_reg <= '0;
      tag2  <= '0;
    end else begin
      if (ld1) begin
        x_reg <= x_next;
        tag1  <= tag_in;
      end
      if (ld2) begin
        s_reg <= s_next;
        tag2  <= tag1;
      end
      v1 <= ld1 | (v1 & !ready2);
      v2 <= ld2 | (v2 & !out_ready);
    end
  end

  assign out_valid = v2;
  assign s_out     = s_reg;
  assign tag_out   = tag2;

endmodule

// File: tb/tb_des_sbox_stage.sv
// Scoreboard bench for des_sbox_stage: a table-driven DES f-front-half model
// predicts each accepted item; a monitor pops and compares on every output.
module tb_des_sbox_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] r_in = '0;
  logic [47:0] k_in = '0;
  logic [7:0]  tag_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] s_out;
  logic [7:0]  tag_out;

  des_sbox_stage #(.TAG_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .r_in(r_in), .k_in(k_in), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .s_out(s_out), .tag_out(tag_out)
  );

  always #5 clk = ~clk;

  // DES tables in the usual decimal form; bit n of a word is numbered from 1 at the MSB.
  int etab [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                    16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  int ptab [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                    2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  int sb [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };

  function automatic logic [31:0] ref_f(logic [31:0] r, logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    int g, row, col;
    for (int j = 0; j < 48; j++) x[47-j] = r[32-etab[j]] ^ k[47-j];
    s = '0;
    for (int i = 0; i < 8; i++) begin
      g   = int'((x >> (42 - 6*i)) & 48'h3F);
      row = ((g >> 5) & 1) * 2 + (g & 1);
      col = (g >> 1) & 15;
      s   = (s << 4) | 32'(sb[i][row*16 + col]);
    end
    return s;
  endfunction

  function automatic logic [31:0] ref_p(logic [31:0] s);
    logic [31:0] p;
    for (int j = 0; j < 32; j++) p[31-j] = s[32-ptab[j]];
    return p;
  endfunction

  typedef struct {
    logic [31:0] s;
    logic [7:0]  tag;
    int          acc_cyc;
    bit          chk_lat;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0, n_bad = 0;
  int          cyc = 0, acc_cnt = 0, n_out = 0, drops = 0;
  int          prev_out_cyc = 0, last_out_cyc = 0;
  bit          lat_mode = 1'b0, streaming = 1'b0, held = 1'b0, rnd_done = 1'b0;
  logic [31:0] held_s, last_s;
  logic [7:0]  held_tag, last_tag;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Acceptor: a handshake seen mid-cycle transfers on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      q.push_back('{s: ref_f(r_in, k_in), tag: tag_in, acc_cyc: cyc, chk_lat: lat_mode});
      acc_cnt++;
    end
    if (rst_n && streaming && in_valid && !in_ready) drops++;
  end

  // Monitor: hold-stability while stalled, then pop-and-compare on each transfer.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("stall_hold_s", s_out, held_s);
        check("stall_hold_tag", tag_out, held_tag);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_output", out_valid, 1'b0);
        end else begin
          e = q.pop_front();
          check("s_out", s_out, e.s);
          check("tag_out", tag_out, e.tag);
          if (e.chk_lat) check("latency", cyc - e.acc_cyc, 2);
        end
        last_s = s_out;
        last_tag = tag_out;
        prev_out_cyc = last_out_cyc;
        last_out_cyc = cyc;
        n_out++;
      end
      held = out_valid && !out_ready;
      held_s = s_out;
      held_tag = tag_out;
    end
  end

  // Present one item and hold it until accepted; returns just after the accepting edge.
  task automatic send(logic [31:0] r, logic [47:0] k, logic [7:0] t);
    int n = 0;
    r_in = r; k_in = k; tag_in = t; in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 100);
    if (!in_ready) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int i = 0; i < 60 && q.size() > 0; i++) @(negedge clk);
    check("drain_empty", q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, outs0;
    logic [47:0] xv;

    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_s_out", s_out, 0);
    check("rst_tag_out", tag_out, 0);
    #22 rst_n = 1'b1;
    @(posedge clk); #1;

    // Zero vector and the FIPS round-1 vector, unstalled.
    lat_mode = 1'b1;
    send(32'h0, 48'h0, 8'h01);
    drain();
    check("zero_s", last_s, 32'hEFA72C4D);
    check("zero_tag", last_tag, 8'h01);

    send(32'hF0AAF0AA, 48'h1B02EFFC7072, 8'h02);
    xv = dut.x_reg;
    check("fips_x_reg", xv, 48'h6117BA866527);
    drain();
    check("fips_s", last_s, 32'h5C82B597);
    check("fips_perm", ref_p(last_s), 32'h234AA9BB);

    // Streaming: 16 back-to-back items at full throughput.
    streaming = 1'b1;
    outs0 = n_out;
    for (int i = 0; i < 16; i++) send($urandom(), {16'($urandom()), 32'($urandom())}, 8'($urandom()));
    drain();
    streaming = 1'b0;
    check("stream_no_stall", drops, 0);
    check("stream_count", n_out - outs0, 16);

    // Backpressure: 4 items offered while out_ready is low for 5 cycles.
    lat_mode = 1'b0;
    out_ready = 1'b0;
    base = acc_cnt;
    outs0 = n_out;
    fork
      begin
        for (int i = 0; i < 4; i++) send($urandom(), {16'($urandom()), 32'($urandom())}, 8'(8'h40 + i));
        in_valid = 1'b0;
      end
      begin
        for (int c = 1; c <= 5; c++) begin
          @(negedge clk);
          if (c >= 3) check("bp_in_ready_low", in_ready, 0);
        end
        @(posedge clk); #1;
        check("bp_captured", acc_cnt - base, 2);
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_drained", n_out - outs0, 4);

    // Reset with both stages full discards everything in flight.
    out_ready = 1'b0;
    send(32'h12345678, 48'h9ABCDEF01234, 8'hA1);
    send(32'h87654321, 48'h43210FEDCBA9, 8'hA2);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_s_out", s_out, 0);
    check("midrst_tag_out", tag_out, 0);
    check("midrst_in_ready", in_ready, 1);
    q.delete();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    lat_mode = 1'b1;
    @(posedge clk); #1;
    outs0 = n_out;
    send(32'hCAFEF00D, 48'h0123456789AB, 8'h5A);
    drain();
    check("post_rst_count", n_out - outs0, 1);

    // Simultaneous accept / advance / emit with both stages full.
    lat_mode = 1'b0;
    out_ready = 1'b0;
    send(32'h11111111, 48'h222222222222, 8'hC1);
    send(32'h33333333, 48'h444444444444, 8'hC2);
    out_ready = 1'b1;
    #1;
    check("simul_out_valid", out_valid, 1);
    check("simul_in_ready", in_ready, 1);
    send(32'h55555555, 48'h666666666666, 8'hC3);
    drain();
    check("simul_b_then_c", last_out_cyc - prev_out_cyc, 1);

    // Random traffic under random backpressure.
    outs0 = n_out;
    fork
      begin
        for (int i = 0; i < 40; i++) send($urandom(), {16'($urandom()), 32'($urandom())}, 8'($urandom()));
        in_valid = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check("random_count", n_out - outs0, 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/des_sbox_stage.md
Name: des_sbox_stage

Overview:
- Two-stage pipelined front half of the DES round function f.
- Takes the right half R and the round subkey K, and performs the E-expansion and the key XOR.
- Runs the eight DES S-boxes on the result and produces the 32-bit S-box output consumed directly by the Permutation block.
- Uses a valid/ready elastic handshake so it can sit inside the pipelined round datapath with backpressure.

Parameters:
TAG_W, 8, width of an opaque sideband tag (e.g. round index / L-half pointer) carried in lockstep with the data.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  reset, asynchronous and active-low
in_valid  input  1  R/K/tag presented this cycle
in_ready  output  1  stage can accept input this cycle
r_in  input  [0:31]  right half R, bit 0 = DES bit 1 (MSB-first numbering)
k_in  input  [0:47]  round subkey, bit 0 = DES bit 1
tag_in  input  [TAG_W-1:0]  sideband tag
out_valid  output  1  s_out/tag_out valid
out_ready  input  1  downstream (Permutation/XOR stage) accepts
s_out  output  [0:31]  concatenated S1..S8 outputs, S1 in bits 0..3
tag_out  output  [TAG_W-1:0]  tag matching s_out

Behaviour:
- Reset (rst_n low, asynchronous):
  - v1 and v2 (stage valids) clear to 0, so out_valid = 0.
  - x_reg[0:47], s_out and tag registers clear to 0.
  - in_ready is 1 while in reset.
  - Reset asserted mid-flight discards all in-flight items; no output is produced for them.
- Stage 1:
  - x = E(r_in) XOR k_in, using the FIPS 46-3 E table: E[j] = r_in[Etab[j]-1], with Etab = 32,1,2,3,4,5,4,5,...,31,32,1.
  - x and tag are registered into x_reg / tag1 and set v1 on a stage-1 load.
- Stage 2:
  - For i = 0..7, the group g = x_reg[6i:6i+5] selects row = {g[0],g[5]} and col = g[1:4].
  - s_out[4i:4i+3] = S_{i+1}[row][col], per the FIPS 46-3 tables.
  - Each table is held as a 256-bit constant; entry n = row*16+col occupies nibble bits [4n:4n+3].
  - Result and tag1 are registered into s_out / tag_out and set v2.
- Handshake (elastic, no bubbles at full throughput):
  - ready2 = !v2 | out_ready.
  - ready1 = !v1 | ready2.
  - in_ready = ready1 (combinational from out_ready).
  - A stage-1 load occurs when in_valid & in_ready. A stage-2 load occurs when v1 & ready2.
  - v1_next = (in_valid & in_ready) | (v1 & !ready2).
  - v2_next = (v1 & ready2) | (v2 & !out_ready).
- Data integrity:
  - Data and tag registers change only on their stage's load.
  - While out_valid & !out_ready, s_out and tag_out hold stable.
- Latency and throughput:
  - Input accepted at edge N appears on out_valid at edge N+2 when unstalled.
  - Sustained throughput is 1 item/cycle with out_ready tied high.
- Simultaneous events:
  - Accept and emit in the same cycle is legal.
  - With both stages full and out_ready = 1, all three transfers (in, 1->2, out) occur on the same edge.
- Full condition:
  - With v1 = v2 = 1 and out_ready = 0, in_ready = 0. Inputs presented then are not captured and must be held by the source.
- No combinational path from r_in/k_in to any output.
- in_valid while in_ready = 0 has no effect.

Test Plan:
- Zero vector: r_in=0, k_in=0, tag=0x01, out_ready=1 -> two cycles later out_valid=1, s_out=32'hEFA72C4D, tag_out=0x01.
- FIPS round-1 vector: r_in=32'hF0AAF0AA, k_in=48'h1B02EFFC7072 -> internal x_reg=48'h6117BA866527; s_out=32'h5C82B597 at latency 2. Chained into Permutation, the result must equal 32'h234AA9BB.
- Streaming: 16 back-to-back random (R,K,tag), out_ready=1 -> 16 consecutive out_valid cycles, in order, matching a software DES model; in_ready never drops.
- Backpressure: hold out_ready=0 for 5 cycles while feeding 4 items -> exactly 2 captured, in_ready=0 from the 3rd presentation on, s_out/tag_out stable. Release -> remaining items drain in order with no loss or duplication.
- Reset mid-flight: assert rst_n=0 with v1=v2=1 -> out_valid drops immediately (asynchronous), s_out=0. After release, the first new input emerges at latency 2 with no stale data.
- Simultaneous event: stages full, out_ready=1, in_valid=1 for one cycle -> same edge emits item A, moves B to stage 2, loads C; outputs on successive cycles are B then C.
